filt_sequencer: RTL and testbench

//  Initiator side of the filters start/done handshake. Buffers XADC samples in a FIFO.
//  For each sample: pulses filt_start, waits for filt_done, captures filt_result.

---
 rtl/filt_sequencer_pkg.sv | 33 +++
 rtl/filt_sequencer_if.sv | 36 +++
 rtl/filt_sequencer_sync_fifo.sv | 64 ++++++
 rtl/filt_sequencer.sv | 150 +++++++++++++++
 tb/tb_filt_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filt_sequencer_pkg.sv
// Shared types, constants and helpers for the filters start/done sequencer.
package filt_sequencer_pkg;

    localparam int XADC_DATA_SIZE = 16;

    localparam logic [1:0] FILT_SEL_LPF = 2'b00;
    localparam logic [1:0] FILT_SEL_HPF = 2'b01;
    localparam logic [1:0] FILT_SEL_BPF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    // The reserved select code falls back to the low-pass filter.
    function automatic logic [1:0] map_sel(input logic [1:0] sel);
        logic [1:0] res;
        case (sel)
            FILT_SEL_HPF: res = FILT_SEL_HPF;
            FILT_SEL_BPF: res = FILT_SEL_BPF;
            default:      res = FILT_SEL_LPF;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/filt_sequencer_if.sv
// Bundle of the sample input, filters handshake, result output and status signals.
// Handshakes: in_valid/in_ready and out_valid/out_ready transfer on a clock edge where both are high;
// a valid, once raised, holds its data stable until that edge.
interface filt_sequencer_if
    import filt_sequencer_pkg::*;
#(
    parameter int DW = XADC_DATA_SIZE
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [1:0]    sel_in;
    logic          filt_start;
    logic [1:0]    filt_select;
    logic [DW-1:0] filt_sample;
    logic [DW-1:0] filt_result;
    logic          filt_done;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          err_timeout;
    logic [7:0]    drop_count;
    seq_state_e    dbg_state;

    modport master (
        input  in_valid, in_data, sel_in, filt_result, filt_done, out_ready,
        output in_ready, filt_start, filt_select, filt_sample, out_valid, out_data,
               err_timeout, drop_count, dbg_state
    );

    modport slave (
        output in_valid, in_data, sel_in, filt_result, filt_done, out_ready,
        input  in_ready, filt_start, filt_select, filt_sample, out_valid, out_data,
               err_timeout, drop_count, dbg_state
    );
endinterface

// File: rtl/filt_sequencer_sync_fifo.sv
// Single-clock FIFO; the head word is presented straight from registered storage.
module filt_sequencer_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/filt_sequencer.sv
// Feeds buffered XADC samples one at a time through the filters start/done handshake
// and holds each captured result on a valid/ready output.
module filt_sequencer
    import filt_sequencer_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    filt_sequencer_if.master bus
);
    localparam int DW = XADC_DATA_SIZE;
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          push, pop, drop, timeout, done_evt, out_fire;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] fifo_rd_data;

    seq_state_e    state_q, state_d;
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          filt_start_q, filt_start_d;
    logic [1:0]    filt_select_q, filt_select_d;
    logic [DW-1:0] filt_sample_q, filt_sample_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          err_timeout_q, err_timeout_d;
    logic [7:0]    drop_count_q, drop_count_d;

    assign push = bus.in_valid & ~fifo_full;
    assign drop = bus.in_valid & fifo_full;

    filt_sequencer_sync_fifo #(
        .WIDTH (DW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.in_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        timer_d       = timer_q;
        done_d        = bus.filt_done;
        filt_start_d  = filt_start_q;
        filt_select_d = filt_select_q;
        filt_sample_d = filt_sample_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        err_timeout_d = 1'b0;
        pop           = 1'b0;
        timeout       = 1'b0;
        done_evt      = bus.filt_done & ~done_q;
        out_fire      = out_valid_q & bus.out_ready;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            // The output slot counts as free when it is being drained this cycle,
            // so a held-high out_ready gives back-to-back samples.
            ST_IDLE: begin
                if (!fifo_empty && (!out_valid_q || bus.out_ready)) begin
                    pop           = 1'b1;
                    filt_sample_d = fifo_rd_data;
                    filt_select_d = map_sel(bus.sel_in);
                    filt_start_d  = 1'b1;
                    start_cnt_d   = '0;
                    state_d       = ST_START;
                end
            end
            ST_START: begin
                if (start_cnt_q == SW'(START_CYCLES - 1)) begin
                    filt_start_d = 1'b0;
                    timer_d      = '0;
                    state_d      = ST_WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end
            ST_WAIT: begin
                if (done_evt) begin
                    out_data_d  = bus.filt_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    timeout       = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drop_count_d = sat_add8(drop_count_q, {1'b0, drop} + {1'b0, timeout});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_cnt_q   <= '0;
            timer_q       <= '0;
            done_q        <= 1'b0;
            filt_start_q  <= 1'b0;
            filt_select_q <= '0;
            filt_sample_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            err_timeout_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            timer_q       <= timer_d;
            done_q        <= done_d;
            filt_start_q  <= filt_start_d;
            filt_select_q <= filt_select_d;
            filt_sample_q <= filt_sample_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            err_timeout_q <= err_timeout_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign bus.in_ready    = ~fifo_full;
    assign bus.filt_start  = filt_start_q;
    assign bus.filt_select = filt_select_q;
    assign bus.filt_sample = filt_sample_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.drop_count  = drop_count_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_filt_sequencer.sv
// Directed bench for filt_sequencer: a filter model answers the start/done handshake
// and a monitor compares every accepted result against the expected queue.
module tb_filt_sequencer;

    localparam int START_CYCLES = 2;
    localparam int RESP_LAT     = 8;
    localparam int FM_OFF       = 0;
    localparam int FM_QUEUE     = 1;
    localparam int FM_HPF       = 2;
    localparam int FM_SILENT    = 3;

    logic clk;
    logic rst;

    filt_sequencer_if bus ();

    filt_sequencer #(
        .FIFO_AW        (3),
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_starts = 0;
    int          filt_mode = FM_OFF;
    logic [15:0] exp_q [$];
    logic [15:0] smp_q [$];
    logic [1:0]  sel_q [$];
    logic [15:0] rsp_q [$];
    logic        mdl_done = 1'b0;
    logic [15:0] mdl_result = 16'h0;
    logic        stale_done = 1'b0;
    logic [15:0] stale_result = 16'h0;
    logic [15:0] hpf_prev = 16'h0;
    logic [15:0] mdl_smp;
    logic [1:0]  mdl_sel;
    int          mdl_hi;

    assign bus.filt_done   = mdl_done | stale_done;
    assign bus.filt_result = mdl_done ? mdl_result : (stale_done ? stale_result : 16'hDEAD);

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        smp_q.delete();
        sel_q.delete();
        rsp_q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_filt_start"}, bus.filt_start, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_drop_count"}, bus.drop_count, 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
        check({tag, "_state"}, bus.dbg_state, 0);
    endtask

    // Presents one sample for one clock; leaves in_valid high for back-to-back use.
    task automatic push_sample(input logic [15:0] d, input logic exp_acc);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        check("in_ready", bus.in_ready, exp_acc);
        if (exp_acc) begin
            smp_q.push_back(d);
            sel_q.push_back(exp_sel(bus.sel_in));
        end
        @(negedge clk);
    endtask

    task automatic wait_start_fall(input string tag);
        int n = 0;
        while (!bus.filt_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (bus.filt_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, (n < 50), 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus.dbg_state != 0 || bus.out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- filter model ----------------
    initial begin : filt_model
        forever begin
            @(negedge clk);
            if (rst) begin
                hpf_prev = 16'h0;
            end else if (bus.filt_start && filt_mode != FM_OFF) begin
                n_starts++;
                mdl_smp = bus.filt_sample;
                mdl_sel = bus.filt_select;
                if (smp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL start_unexpected: sample %h with nothing queued", mdl_smp);
                end else begin
                    check("filt_sample", mdl_smp, smp_q.pop_front());
                    check("filt_select", mdl_sel, sel_q.pop_front());
                end
                mdl_hi = 1;
                forever begin
                    @(negedge clk);
                    if (rst || !bus.filt_start || mdl_hi >= 8) break;
                    mdl_hi++;
                end
                if (!rst) check("start_width", mdl_hi, START_CYCLES);
                if (!rst && (filt_mode == FM_QUEUE || filt_mode == FM_HPF)) begin
                    repeat (RESP_LAT) @(negedge clk);
                    check("select_stable", bus.filt_select, mdl_sel);
                    check("sample_stable", bus.filt_sample, mdl_smp);
                    if (filt_mode == FM_HPF) begin
                        mdl_result = mdl_smp - hpf_prev;
                        hpf_prev   = mdl_smp;
                    end else if (rsp_q.size() != 0) begin
                        mdl_result = rsp_q.pop_front();
                    end else begin
                        mdl_result = 16'hDEAD;
                    end
                    mdl_done = 1'b1;
                    @(negedge clk);
                    mdl_done = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got %h with empty expected queue", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] t3_smp [8] = '{16'h0100, 16'h0180, 16'h0150, 16'h0400,
                                16'h03FF, 16'h0000, 16'h8000, 16'hFFFF};
    logic [15:0] t3_exp [8] = '{16'h0100, 16'h0080, 16'hFFD0, 16'h02B0,
                                16'hFFFF, 16'hFC01, 16'h8000, 16'h7FFF};
    logic [15:0] t4_rsp [9] = '{16'h4444, 16'h1001, 16'h2002, 16'h3003, 16'h5005,
                                16'h6006, 16'h7007, 16'h8008, 16'h9009};

    initial begin : main
        int n;
        int base;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.sel_in   = 2'b00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b0;
        @(negedge clk);

        // 1: reset asserted while filt_start is high
        filt_mode = FM_OFF;
        push_sample(16'h0F0F, 1'b1);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.filt_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t1_start_seen", bus.filt_start, 1);
        rst = 1'b1;
        #1;
        check_reset_state("t1_mid_start");
        do_reset();

        // 2: single sample, HPF select, 2-clock push-to-start latency
        filt_mode     = FM_QUEUE;
        bus.sel_in    = 2'b01;
        bus.out_ready = 1'b1;
        rsp_q.push_back(16'h0ABC);
        exp_q.push_back(16'h0ABC);
        push_sample(16'h1234, 1'b1);
        bus.in_valid = 1'b0;
        check("t2_latency_1", bus.filt_start, 0);
        @(negedge clk);
        check("t2_latency_2", bus.filt_start, 1);
        drain("t2");

        // 3: streaming HPF samples, reserved select code maps to LPF
        do_reset();
        filt_mode     = FM_HPF;
        bus.sel_in    = 2'b11;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(t3_exp[i]);
            push_sample(t3_smp[i], 1'b1);
        end
        bus.in_valid = 1'b0;
        drain("t3");

        // 4: overflow with output stalled, then drop_count saturation
        do_reset();
        filt_mode     = FM_QUEUE;
        bus.sel_in    = 2'b10;
        bus.out_ready = 1'b0;
        base          = n_starts;
        for (int i = 0; i < 9; i++) begin
            rsp_q.push_back(t4_rsp[i]);
            exp_q.push_back(t4_rsp[i]);
        end
        for (int i = 0; i < 10; i++) begin
            push_sample(16'h0A00 + 16'(i), (i < 9));
        end
        bus.in_valid = 1'b0;
        check("t4_drop_one", bus.drop_count, 1);
        repeat (30) @(negedge clk);
        check("t4_one_start", n_starts - base, 1);
        check("t4_out_held", bus.out_valid, 1);
        check("t4_stall_idle", bus.dbg_state, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hEEEE;
        repeat (260) @(negedge clk);
        bus.in_valid = 1'b0;
        check("t4_drop_sat", bus.drop_count, 255);
        bus.out_ready = 1'b1;
        drain("t4");
        check("t4_in_ready_back", bus.in_ready, 1);
        check("t4_drop_sat_hold", bus.drop_count, 255);

        // 5: filter never answers, sample abandoned after the timeout
        do_reset();
        filt_mode     = FM_SILENT;
        bus.sel_in    = 2'b00;
        bus.out_ready = 1'b1;
        rsp_q.push_back(16'h3333);
        exp_q.push_back(16'h3333);
        push_sample(16'hAAAA, 1'b1);
        push_sample(16'hBBBB, 1'b1);
        bus.in_valid = 1'b0;
        wait_start_fall("t5");
        n = 0;
        while (!bus.err_timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        filt_mode = FM_QUEUE;
        check("t5_timeout_clocks", n, 255);
        check("t5_drop_count", bus.drop_count, 1);
        check("t5_no_result", bus.out_valid, 0);
        @(negedge clk);
        check("t5_err_one_clock", bus.err_timeout, 0);
        drain("t5");
        check("t5_drop_count_end", bus.drop_count, 1);

        // 6: done already high before start is stale; only a fresh edge in WAIT captures
        do_reset();
        filt_mode     = FM_SILENT;
        bus.out_ready = 1'b1;
        stale_result  = 16'h5555;
        stale_done    = 1'b1;
        repeat (2) @(negedge clk);
        push_sample(16'h2222, 1'b1);
        bus.in_valid = 1'b0;
        wait_start_fall("t6");
        repeat (5) @(negedge clk);
        check("t6_no_stale_capture", bus.out_valid, 0);
        check("t6_still_waiting", bus.dbg_state, 2);
        stale_done = 1'b0;
        @(negedge clk);
        exp_q.push_back(16'h7777);
        stale_result = 16'h7777;
        stale_done   = 1'b1;
        @(negedge clk);
        stale_done = 1'b0;
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
